io_ctrl: RTL and testbench

Parametrised board I/O controller between the `cpu` port bus (`in_p0..in_p3`, `out_p0..out_p3`, `we_o`, `hilo_in`, `hilo_out`) and the board buttons, switches and LEDs. It is the successor to the combinational port decoder and replaces it in `entorno_cpu`. It adds per-button synchronisation and debouncing, sticky press flags with read-to-clear, switch synchronisation, and nibble-selectable LED writes. It also adds a maskable interrupt request for the CPU.

---
 rtl/io_pkg.sv | 12 +
 rtl/debouncer.sv | 44 ++++
 rtl/io_ctrl.sv | 108 ++++++++++
 tb/tb_io_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants for the board I/O controller: hilo half-select codes and
// the default debounce length.
package io_pkg;

    localparam logic [1:0] HILO_DEF  = 2'b00;
    localparam logic [1:0] HILO_LO   = 2'b01;
    localparam logic [1:0] HILO_HI   = 2'b10;
    localparam logic [1:0] HILO_BOTH = 2'b11;

    localparam int DB_CYCLES_DEF = 50000;

endpackage

// File: rtl/debouncer.sv
// One-button 2-FF synchroniser plus stability counter. rise is a one-cycle
// pulse in the cycle after stb has been accepted high.
module debouncer
    import io_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int DB_W      = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stb,
    output logic rise
);

    logic [1:0]      sync;
    logic [DB_W-1:0] cnt;
    logic            sy;

    assign sy = sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            cnt  <= '0;
            stb  <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            rise <= 1'b0;
            if (sy == stb) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
                // Change accepted; only a press (not a release) raises rise.
                stb  <= sy;
                cnt  <= '0;
                rise <= sy;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_ctrl.sv
// Board I/O controller: debounced buttons with sticky press flags, synced
// switches with half-select reads, nibble-selectable LED writes and an irq.
module io_ctrl
    import io_pkg::*;
#(
    parameter int N_BTN     = 4,
    parameter int SW_W      = 10,
    parameter int LEDV_W    = 8,
    parameter int LEDR_W    = 10,
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int DB_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BTN-1:0]  buttons,
    input  logic [SW_W-1:0]   switches,
    input  logic [7:0]        out_p0,
    input  logic [7:0]        out_p1,
    input  logic [7:0]        out_p2,
    input  logic [7:0]        out_p3,
    input  logic              we_o,
    input  logic [1:0]        hilo_in,
    input  logic [1:0]        hilo_out,
    input  logic              rd_ack,
    output logic [7:0]        in_p0,
    output logic [7:0]        in_p1,
    output logic [7:0]        in_p2,
    output logic [7:0]        in_p3,
    output logic [LEDV_W-1:0] led_v,
    output logic [LEDR_W-1:0] led_r,
    output logic              irq
);

    localparam int HS = SW_W / 2;
    localparam int HR = LEDR_W / 2;

    logic [N_BTN-1:0] stb;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] flag;
    logic [SW_W-1:0]  sw_meta;
    logic [SW_W-1:0]  sw_sync;
    logic             irq_en;
    logic             unused_bits;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        debouncer #(
            .DB_CYCLES (DB_CYCLES),
            .DB_W      (DB_W)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .din   (~buttons[gi]),
            .stb   (stb[gi]),
            .rise  (rise[gi])
        );
    end

    // A new press in the same cycle as rd_ack survives the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag <= '0;
        end else begin
            flag <= (rd_ack ? '0 : flag) | rise;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_v  <= '0;
            led_r  <= '0;
            irq_en <= 1'b0;
        end else if (we_o) begin
            led_v  <= out_p0[LEDV_W-1:0];
            irq_en <= out_p3[0];
            case (hilo_out)
                HILO_LO: led_r[HR-1:0]      <= out_p1[HR-1:0];
                HILO_HI: led_r[LEDR_W-1:HR] <= out_p2[HR-1:0];
                default: led_r              <= {out_p2[HR-1:0], out_p1[HR-1:0]};
            endcase
        end
    end

    always_comb begin
        in_p0 = '0;
        in_p1 = '0;
        in_p2 = '0;
        in_p3 = '0;
        in_p0[N_BTN-1:0] = stb;
        in_p1[N_BTN-1:0] = flag;
        if (hilo_in != HILO_HI) in_p2[HS-1:0] = sw_sync[HS-1:0];
        if (hilo_in != HILO_LO) in_p3[HS-1:0] = sw_sync[SW_W-1:HS];
    end

    assign irq = irq_en & (|flag);

    assign unused_bits = ^{out_p0, out_p1, out_p2, out_p3[7:1]};

endmodule

// File: tb/tb_io_ctrl.sv
// Self-checking bench for io_ctrl with DB_CYCLES = 4: directed tables and
// sequences plus randomized traffic against a window-based reference model.
module tb_io_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'hF;
    logic [9:0] sw = '0;
    logic [7:0] op0 = '0, op1 = '0, op2 = '0, op3 = '0;
    logic       we = 1'b0;
    logic [1:0] hin = 2'b00, hout = 2'b00;
    logic       rd = 1'b0;
    logic [7:0] in_p0, in_p1, in_p2, in_p3;
    logic [7:0] led_v;
    logic [9:0] led_r;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [3:0] samp[$];
    logic [3:0] m_stb, m_rise, m_flag;
    logic [9:0] m_sw_meta, m_sw;
    logic [7:0] m_led_v;
    logic [9:0] m_led_r;
    logic       m_irq_en;

    io_ctrl #(
        .N_BTN(4), .SW_W(10), .LEDV_W(8), .LEDR_W(10), .DB_CYCLES(DB), .DB_W(4)
    ) dut (
        .clk(clk), .reset(rst_n), .buttons(btn), .switches(sw),
        .out_p0(op0), .out_p1(op1), .out_p2(op2), .out_p3(op3),
        .we_o(we), .hilo_in(hin), .hilo_out(hout), .rd_ack(rd),
        .in_p0(in_p0), .in_p1(in_p1), .in_p2(in_p2), .in_p3(in_p3),
        .led_v(led_v), .led_r(led_r), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        samp.delete();
        for (int j = 0; j <= DB; j++) samp.push_back(4'h0);
        m_stb = '0; m_rise = '0; m_flag = '0;
        m_sw_meta = '0; m_sw = '0;
        m_led_v = '0; m_led_r = '0; m_irq_en = 1'b0;
    endtask

    // A button state is accepted once its synced value (raw input two edges
    // old) has disagreed with the accepted state on DB consecutive edges.
    task automatic model_edge();
        logic [3:0] nstb;
        logic       all_diff;
        for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++)
                if (samp[j][i] == m_stb[i]) all_diff = 1'b0;
            nstb[i] = all_diff ? ~m_stb[i] : m_stb[i];
        end
        m_flag = (rd ? 4'h0 : m_flag) | m_rise;
        m_rise = nstb & ~m_stb;
        m_stb  = nstb;
        void'(samp.pop_front());
        samp.push_back(~btn);
        m_sw      = m_sw_meta;
        m_sw_meta = sw;
        if (we) begin
            m_led_v  = op0;
            m_irq_en = op3[0];
            if (hout == 2'b01)      m_led_r[4:0] = op1[4:0];
            else if (hout == 2'b10) m_led_r[9:5] = op2[4:0];
            else                    m_led_r = {op2[4:0], op1[4:0]};
        end
    endtask

    task automatic check_all();
        logic [7:0] e2, e3;
        e2 = (hin inside {2'b00, 2'b01, 2'b11}) ? {3'b0, m_sw[4:0]} : 8'h00;
        e3 = (hin inside {2'b00, 2'b10, 2'b11}) ? {3'b0, m_sw[9:5]} : 8'h00;
        chk("in_p0", in_p0, {4'h0, m_stb});
        chk("in_p1", in_p1, {4'h0, m_flag});
        chk("in_p2", in_p2, e2);
        chk("in_p3", in_p3, e3);
        chk("led_v", led_v, m_led_v);
        chk("led_r", led_r, m_led_r);
        chk("irq",   irq,   m_irq_en & (|m_flag));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic write(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input logic [1:0] h);
        op0 = a; op1 = b; op2 = c; op3 = d; hout = h; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    typedef struct {
        logic [9:0] sw;
        logic [1:0] hin;
        logic [7:0] p2;
        logic [7:0] p3;
    } sw_vec_t;

    typedef struct {
        logic [7:0] p0, p1, p2;
        logic [1:0] hout;
        logic [7:0] lv;
        logic [9:0] lr;
    } led_vec_t;

    sw_vec_t  sw_tab[5];
    led_vec_t led_tab[4];

    initial begin
        sw_tab[0] = '{10'h3A5, 2'b01, 8'h05, 8'h00};
        sw_tab[1] = '{10'h3A5, 2'b10, 8'h00, 8'h1D};
        sw_tab[2] = '{10'h3A5, 2'b00, 8'h05, 8'h1D};
        sw_tab[3] = '{10'h3A5, 2'b11, 8'h05, 8'h1D};
        sw_tab[4] = '{10'h0E1, 2'b00, 8'h01, 8'h07};
        led_tab[0] = '{8'hA5, 8'h1F, 8'h00, 2'b11, 8'hA5, 10'h01F};
        led_tab[1] = '{8'hA5, 8'h00, 8'h15, 2'b10, 8'hA5, 10'h2BF};
        led_tab[2] = '{8'h3C, 8'h0A, 8'h1F, 2'b01, 8'h3C, 10'h2AA};
        led_tab[3] = '{8'h01, 8'h03, 8'h10, 2'b00, 8'h01, 10'h203};

        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_in_p0", in_p0, 8'h00);
        chk("rst_in_p1", in_p1, 8'h00);
        chk("rst_irq", irq, 1'b0);
        chk("rst_led_r", led_r, 10'h000);
        rst_n = 1'b1;

        // switch half-select table
        foreach (sw_tab[k]) begin
            sw = sw_tab[k].sw; hin = sw_tab[k].hin;
            step(); step();
            chk("sw_p2", in_p2, sw_tab[k].p2);
            chk("sw_p3", in_p3, sw_tab[k].p3);
        end

        // LED write table
        foreach (led_tab[k]) begin
            write(led_tab[k].p0, led_tab[k].p1, led_tab[k].p2, 8'h00, led_tab[k].hout);
            chk("led_v_tab", led_v, led_tab[k].lv);
            chk("led_r_tab", led_r, led_tab[k].lr);
        end

        // clean press with irq enabled
        write(8'h00, 8'h00, 8'h00, 8'h01, 2'b01);
        btn = 4'b1110;
        repeat (5) step();
        chk("press_early", in_p0, 8'h00);
        step();
        chk("press_stb", in_p0, 8'h01);
        chk("press_noflag", in_p1, 8'h00);
        step();
        chk("press_flag", in_p1, 8'h01);
        chk("press_irq", irq, 1'b1);
        rd = 1'b1; step(); rd = 1'b0;
        chk("ack_flag", in_p1, 8'h00);
        chk("ack_irq", irq, 1'b0);

        // bounce on button 1
        for (int ph = 0; ph < 10; ph++) begin
            btn[1] = ph[0];
            repeat (3) begin
                step();
                chk("bounce_stb1", in_p0[1], 1'b0);
            end
        end
        btn[1] = 1'b0;
        repeat (5) step();
        chk("bounce_hold_early", in_p0[1], 1'b0);
        step();
        chk("bounce_hold_stb", in_p0[1], 1'b1);
        repeat (4) step();
        chk("bounce_one_flag", in_p1, 8'h02);
        rd = 1'b1; step(); rd = 1'b0;
        repeat (4) step();
        chk("bounce_no_reflag", in_p1, 8'h00);

        // simultaneous set/clear: release all, then press 0 and 2 staggered
        btn = 4'hF;
        repeat (8) step();
        rd = 1'b1; step(); rd = 1'b0;
        btn[0] = 1'b0; step();
        btn[2] = 1'b0;
        repeat (6) step();
        chk("sc_flag0", in_p1, 8'h01);
        rd = 1'b1; step(); rd = 1'b0;
        chk("sc_flag", in_p1, 8'h04);

        // reset mid-operation
        write(8'hFF, 8'h1F, 8'h1F, 8'h01, 2'b11);
        btn[3] = 1'b0;
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_p0", in_p0, 8'h00);
        chk("mid_rst_p1", in_p1, 8'h00);
        chk("mid_rst_irq", irq, 1'b0);
        chk("mid_rst_led_v", led_v, 8'h00);
        chk("mid_rst_led_r", led_r, 10'h000);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        repeat (5) step();
        chk("rst_rehold_early", in_p0, 8'h00);
        step();
        chk("rst_rehold_stb", in_p0, 8'h0D);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(7) == 0) btn[i] = ~btn[i];
            if ($urandom_range(3) == 0) sw = 10'($urandom);
            hin = 2'($urandom);
            we  = ($urandom_range(4) == 0);
            op0 = 8'($urandom); op1 = 8'($urandom);
            op2 = 8'($urandom); op3 = 8'($urandom);
            hout = 2'($urandom);
            rd  = ($urandom_range(9) == 0);
            step();
        end
        we = 1'b0; rd = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
